scarv_cop_insn_buffer: RTL and testbench

//  Instruction intake buffer between the host CPU coprocessor interface and scarv_cop_idecode.

---
 rtl/scarv_cop_insn_buffer_pkg.sv | 14 +
 rtl/scarv_cop_insn_buffer_if.sv | 30 +++
 rtl/scarv_cop_insn_buffer.sv | 80 ++++++++
 tb/tb_scarv_cop_insn_buffer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scarv_cop_insn_buffer_pkg.sv
// Shared constants and entry type for the coprocessor instruction intake buffer.
// Each queued entry holds the instruction encoding and the rs1 value captured with it.
package scarv_cop_insn_buffer_pkg;

    localparam int unsigned SCARV_COP_INSN_BUF_DEPTH   = 2;
    localparam int unsigned SCARV_COP_INSN_BUF_PTR_W   = 1;
    localparam int unsigned SCARV_COP_INSN_BUF_ENTRY_W = 64;

    typedef struct packed {
        logic [31:0] rs1_val;
        logic [31:0] encoding;
    } insn_entry_t;

endpackage

// File: rtl/scarv_cop_insn_buffer_if.sv
// CPU-side req/ack intake, decoder-side valid/ready head and occupancy of the instruction buffer.
// The slave modport is the buffer's view; the master modport is the surrounding pipeline's view.
interface scarv_cop_insn_buffer_if
    import scarv_cop_insn_buffer_pkg::*;
#(
    parameter int PTR_W = SCARV_COP_INSN_BUF_PTR_W
);

    logic              cpu_insn_req;
    logic              cpu_insn_ack;
    logic [31:0]       cpu_insn_enc;
    logic [31:0]       cpu_rs1_val;
    logic              cpu_flush;
    logic              id_valid;
    logic              id_ready;
    logic [31:0]       id_encoded;
    logic [31:0]       id_rs1_val;
    logic [PTR_W:0]    buf_count;

    modport slave (
        input  cpu_insn_req, cpu_insn_enc, cpu_rs1_val, cpu_flush, id_ready,
        output cpu_insn_ack, id_valid, id_encoded, id_rs1_val, buf_count
    );

    modport master (
        output cpu_insn_req, cpu_insn_enc, cpu_rs1_val, cpu_flush, id_ready,
        input  cpu_insn_ack, id_valid, id_encoded, id_rs1_val, buf_count
    );

endinterface

// File: rtl/scarv_cop_insn_buffer.sv
// DEPTH-entry in-order FIFO between the CPU coprocessor interface and scarv_cop_idecode.
// Define SCARV_COP_INSN_BUF_BYPASS_EN to present an incoming instruction to the decoder while empty.
module scarv_cop_insn_buffer
    import scarv_cop_insn_buffer_pkg::*;
#(
    parameter int DEPTH = SCARV_COP_INSN_BUF_DEPTH,
    parameter int PTR_W = SCARV_COP_INSN_BUF_PTR_W
) (
    input  logic                    g_clk,
    input  logic                    g_resetn,
    scarv_cop_insn_buffer_if.slave  bus
);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    insn_entry_t      storage [DEPTH];

    insn_entry_t      in_entry;
    insn_entry_t      head;
    logic             full;
    logic             empty;
    logic             push;
    logic             wr_en;
    logic             rd_en;

    assign in_entry = '{rs1_val: bus.cpu_rs1_val, encoding: bus.cpu_insn_enc};
    assign full     = (count == (PTR_W + 1)'(DEPTH));
    assign empty    = (count == '0);

    // Ack looks only at registered occupancy, so a full buffer refuses even while it is popping.
    assign bus.cpu_insn_ack = g_resetn & ~full & ~bus.cpu_flush;
    assign push             = bus.cpu_insn_req & bus.cpu_insn_ack;
    assign rd_en            = ~empty & bus.id_ready & ~bus.cpu_flush;

`ifdef SCARV_COP_INSN_BUF_BYPASS_EN
    logic bypass;

    // An incoming instruction consumed straight from the CPU inputs never touches storage.
    assign bypass       = g_resetn & empty & bus.cpu_insn_req & ~bus.cpu_flush;
    assign wr_en        = push & ~(bypass & bus.id_ready);
    assign bus.id_valid = ~empty | bypass;
    assign head         = ~empty ? storage[rd_ptr] : (bypass ? in_entry : '0);
`else
    assign wr_en        = push;
    assign bus.id_valid = ~empty;
    assign head         = empty ? '0 : storage[rd_ptr];
`endif

    assign bus.id_encoded = head.encoding;
    assign bus.id_rs1_val = head.rs1_val;
    assign bus.buf_count  = count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            // NOTE: storage is cleared on reset so stale entries can never reach the decoder.
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (bus.cpu_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                storage[wr_ptr] <= in_entry;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (PTR_W + 1)'(wr_en) - (PTR_W + 1)'(rd_en);
        end
    end

endmodule

// File: tb/tb_scarv_cop_insn_buffer.sv
// Self-checking bench for scarv_cop_insn_buffer against a queue-based reference model.
// Build with SCARV_COP_INSN_BUF_BYPASS_EN defined to also exercise the zero-latency path.
module tb_scarv_cop_insn_buffer;
    import scarv_cop_insn_buffer_pkg::*;

    localparam int DEPTH = SCARV_COP_INSN_BUF_DEPTH;
    localparam int PTR_W = SCARV_COP_INSN_BUF_PTR_W;
`ifdef SCARV_COP_INSN_BUF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic g_clk    = 1'b0;
    logic g_resetn = 1'b0;
    always #5 g_clk = ~g_clk;

    scarv_cop_insn_buffer_if #(.PTR_W(PTR_W)) bus ();

    scarv_cop_insn_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .bus      (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] mq [$];

    logic        e_ack, e_valid, popped;
    logic [63:0] e_head, popped_val;

    task automatic drive(input logic req, input logic [31:0] enc, input logic [31:0] rs1,
                         input logic flush, input logic ready);
        bus.cpu_insn_req = req;
        bus.cpu_insn_enc = enc;
        bus.cpu_rs1_val  = rs1;
        bus.cpu_flush    = flush;
        bus.id_ready     = ready;
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    // Expected combinational view for the current inputs and queued contents.
    function automatic void model_expect(output logic ack, output logic valid, output logic [63:0] head);
        ack   = (mq.size() < DEPTH) && !bus.cpu_flush;
        valid = (mq.size() != 0);
        head  = valid ? mq[0] : 64'd0;
        if (BYPASS && mq.size() == 0 && bus.cpu_insn_req && !bus.cpu_flush) begin
            valid = 1'b1;
            head  = {bus.cpu_rs1_val, bus.cpu_insn_enc};
        end
    endfunction

    task automatic model_commit(output logic pop, output logic [63:0] pop_val);
        logic        ack, valid, push;
        logic [63:0] head;
        model_expect(ack, valid, head);
        pop     = 1'b0;
        pop_val = 64'd0;
        if (bus.cpu_flush) begin
            mq.delete();
        end else begin
            push = bus.cpu_insn_req && ack;
            if (valid && bus.id_ready) begin
                pop     = 1'b1;
                pop_val = head;
                if (mq.size() != 0) void'(mq.pop_front());
                else push = 1'b0;
            end
            if (push) mq.push_back({bus.cpu_rs1_val, bus.cpu_insn_enc});
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 32'h0000_0055, 32'h0000_00AA, 1'b0, 1'b0);
        repeat (3) @(posedge g_clk);
        #2;
        n_checks++;
        if (bus.cpu_insn_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", bus.cpu_insn_ack); end
        n_checks++;
        if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.id_valid); end
        n_checks++;
        if ({bus.id_rs1_val, bus.id_encoded} !== 64'd0) begin
            n_fail++; $display("FAIL reset_head: got %h expected 0", {bus.id_rs1_val, bus.id_encoded});
        end
        n_checks++;
        if (bus.buf_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.buf_count); end
        @(negedge g_clk);
        g_resetn = 1'b1;
        #1;
        n_checks++;
        if (bus.cpu_insn_ack !== 1'b1) begin n_fail++; $display("FAIL reset_release_ack: got %b expected 1", bus.cpu_insn_ack); end
        mq.delete();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_fill();
        logic        req_t   [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
        logic [31:0] enc_t   [8] = '{1, 2, 3, 3, 3, 0, 0, 0};
        logic        ready_t [8] = '{0, 0, 0, 1, 1, 1, 1, 1};
        logic [63:0] got [$];
        for (int s = 0; s < 8; s++) begin
            drive(req_t[s], enc_t[s], enc_t[s] ^ 32'hF0F0_0000, 1'b0, ready_t[s]);
            #1;
            model_expect(e_ack, e_valid, e_head);
            n_checks++;
            if (bus.cpu_insn_ack !== e_ack) begin n_fail++; $display("FAIL fill_ack step %0d: got %b expected %b", s, bus.cpu_insn_ack, e_ack); end
            n_checks++;
            if (bus.id_valid !== e_valid) begin n_fail++; $display("FAIL fill_valid step %0d: got %b expected %b", s, bus.id_valid, e_valid); end
            n_checks++;
            if ({bus.id_rs1_val, bus.id_encoded} !== e_head) begin
                n_fail++; $display("FAIL fill_head step %0d: got %h expected %h", s, {bus.id_rs1_val, bus.id_encoded}, e_head);
            end
            model_commit(popped, popped_val);
            if (popped) got.push_back(popped_val);
            tick();
            n_checks++;
            if (bus.buf_count !== (PTR_W + 1)'(mq.size())) begin
                n_fail++; $display("FAIL fill_count step %0d: got %0d expected %0d", s, bus.buf_count, mq.size());
            end
        end
        n_checks++;
        if (got.size() != 3 || got[0][31:0] != 32'd1 || got[1][31:0] != 32'd2 || got[2][31:0] != 32'd3) begin
            n_fail++; $display("FAIL fill_order: got %0d entries expected 1,2,3 in order", got.size());
        end
    endtask

    task automatic test_wrap();
        int next_id  = 1;
        int expect_id = 1;
        int cycles   = 0;
        while (expect_id <= 10 && cycles < 40) begin
            drive(next_id <= 10, 32'(next_id), 32'(next_id) << 8, 1'b0, 1'b1);
            #1;
            model_expect(e_ack, e_valid, e_head);
            n_checks++;
            if (bus.id_valid !== e_valid) begin n_fail++; $display("FAIL wrap_valid cycle %0d: got %b expected %b", cycles, bus.id_valid, e_valid); end
            n_checks++;
            if ({bus.id_rs1_val, bus.id_encoded} !== e_head) begin
                n_fail++; $display("FAIL wrap_head cycle %0d: got %h expected %h", cycles, {bus.id_rs1_val, bus.id_encoded}, e_head);
            end
            if (bus.cpu_insn_req && e_ack) next_id++;
            model_commit(popped, popped_val);
            if (popped) begin
                n_checks++;
                if (popped_val[31:0] != 32'(expect_id)) begin
                    n_fail++; $display("FAIL wrap_order: got id %0d expected %0d", popped_val[31:0], expect_id);
                end
                expect_id++;
            end
            tick();
            cycles++;
            n_checks++;
            if (bus.buf_count > (PTR_W + 1)'(1)) begin n_fail++; $display("FAIL wrap_count: got %0d expected <=1", bus.buf_count); end
        end
        n_checks++;
        if (expect_id != 11) begin n_fail++; $display("FAIL wrap_timeout: got %0d ids expected 10", expect_id - 1); end
    endtask

    task automatic test_flush();
        logic        req_t   [7] = '{1, 1, 1, 1, 0, 0, 0};
        logic [31:0] enc_t   [7] = '{32'hA0, 32'hB0, 32'hBAD, 32'hDEADBEEF, 0, 0, 0};
        logic        flush_t [7] = '{0, 0, 1, 0, 0, 0, 0};
        logic        ready_t [7] = '{0, 0, 1, 0, 0, 1, 0};
        logic [63:0] got [$];
        for (int s = 0; s < 7; s++) begin
            drive(req_t[s], enc_t[s], 32'h1000_0000 + 32'(s), flush_t[s], ready_t[s]);
            #1;
            model_expect(e_ack, e_valid, e_head);
            n_checks++;
            if (bus.cpu_insn_ack !== e_ack) begin n_fail++; $display("FAIL flush_ack step %0d: got %b expected %b", s, bus.cpu_insn_ack, e_ack); end
            n_checks++;
            if (bus.id_valid !== e_valid) begin n_fail++; $display("FAIL flush_valid step %0d: got %b expected %b", s, bus.id_valid, e_valid); end
            n_checks++;
            if ({bus.id_rs1_val, bus.id_encoded} !== e_head) begin
                n_fail++; $display("FAIL flush_head step %0d: got %h expected %h", s, {bus.id_rs1_val, bus.id_encoded}, e_head);
            end
            model_commit(popped, popped_val);
            if (popped) got.push_back(popped_val);
            tick();
            n_checks++;
            if (bus.buf_count !== (PTR_W + 1)'(mq.size())) begin
                n_fail++; $display("FAIL flush_count step %0d: got %0d expected %0d", s, bus.buf_count, mq.size());
            end
        end
        n_checks++;
        if (got.size() != 1 || got[0][31:0] != 32'hDEADBEEF) begin
            n_fail++; $display("FAIL flush_survivor: got %0d entries expected only DEADBEEF", got.size());
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h0BAD_F00D, 32'h1234_0000, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        #2;
        n_checks++;
        if (bus.buf_count !== (PTR_W + 1)'(1) || bus.id_valid !== 1'b1) begin
            n_fail++; $display("FAIL areset_pre: got count %0d valid %b expected 1 1", bus.buf_count, bus.id_valid);
        end
        g_resetn = 1'b0;
        #1;
        n_checks++;
        if (bus.id_valid !== 1'b0 || bus.id_encoded !== 32'd0 || bus.id_rs1_val !== 32'd0) begin
            n_fail++; $display("FAIL areset_head: got valid %b enc %h rs1 %h expected 0 0 0", bus.id_valid, bus.id_encoded, bus.id_rs1_val);
        end
        n_checks++;
        if (bus.buf_count !== '0 || bus.cpu_insn_ack !== 1'b0) begin
            n_fail++; $display("FAIL areset_count: got count %0d ack %b expected 0 0", bus.buf_count, bus.cpu_insn_ack);
        end
        mq.delete();
        #2;
        g_resetn = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 2) != 0));
            #1;
            model_expect(e_ack, e_valid, e_head);
            n_checks++;
            if (bus.cpu_insn_ack !== e_ack) begin n_fail++; $display("FAIL rand_ack cycle %0d: got %b expected %b", c, bus.cpu_insn_ack, e_ack); end
            n_checks++;
            if (bus.id_valid !== e_valid) begin n_fail++; $display("FAIL rand_valid cycle %0d: got %b expected %b", c, bus.id_valid, e_valid); end
            n_checks++;
            if ({bus.id_rs1_val, bus.id_encoded} !== e_head) begin
                n_fail++; $display("FAIL rand_head cycle %0d: got %h expected %h", c, {bus.id_rs1_val, bus.id_encoded}, e_head);
            end
            model_commit(popped, popped_val);
            tick();
            n_checks++;
            if (bus.buf_count !== (PTR_W + 1)'(mq.size())) begin
                n_fail++; $display("FAIL rand_count cycle %0d: got %0d expected %0d", c, bus.buf_count, mq.size());
            end
        end
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        model_commit(popped, popped_val);
        tick();
    endtask

`ifdef SCARV_COP_INSN_BUF_BYPASS_EN
    task automatic test_bypass();
        drive(1'b1, 32'h1234_5678, 32'h8765_4321, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (bus.id_valid !== 1'b1 || bus.id_encoded !== 32'h1234_5678 || bus.id_rs1_val !== 32'h8765_4321) begin
            n_fail++; $display("FAIL bypass_same_cycle: got valid %b enc %h expected 1 12345678", bus.id_valid, bus.id_encoded);
        end
        model_commit(popped, popped_val);
        tick();
        n_checks++;
        if (bus.buf_count !== '0) begin n_fail++; $display("FAIL bypass_consumed_count: got %0d expected 0", bus.buf_count); end
        drive(1'b1, 32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0);
        model_commit(popped, popped_val);
        tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (bus.buf_count !== (PTR_W + 1)'(1) || bus.id_encoded !== 32'h1234_5678) begin
            n_fail++; $display("FAIL bypass_stored: got count %0d enc %h expected 1 12345678", bus.buf_count, bus.id_encoded);
        end
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        model_commit(popped, popped_val);
        tick();
    endtask
`endif

    initial begin
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        test_reset();
        test_fill();
        test_wrap();
        test_flush();
        test_async_reset();
`ifdef SCARV_COP_INSN_BUF_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
